// File: rtl/oem_write_scheduler.sv
// oem_write_scheduler
//   Back-end sequencer for the STI_DAC path. Assembles the serial so_data/so_valid stream into
//   bytes (MSB first) and writes each byte into one of eight 32x8 banks chosen by checkerboard
//   parity and 64-pixel group. Pixels the stream does not supply are written with FILL_VALUE,
//   after which oem_finish is raised and held.
//
//   Ports
//     clk, reset                 clock (rising edge), async active-low reset
//     so_data, so_valid          serial bit and its qualifier
//     pi_end                     level; stream complete once so_valid is low
//     oem_addr[4:0]              bank word address (pixel n[5:1])
//     oem_dataout[7:0]           bank write data
//     odd1_wr..odd4_wr           write strobes, ODD banks 1-4
//     even1_wr..even4_wr         write strobes, EVEN banks 1-4
//     oem_finish                 frame complete, sticky
//     overflow                   byte arrived after pixel 255, sticky
//
//   state | meaning
//   IDLE  | wait for a held byte or the end-of-stream fill condition
//   SETUP | addr/data driven, strobes low
//   PULSE | one selected write strobe high for one cycle
//   GAP   | strobes low, advance pixel counter, free hold register
//   FILL  | end of stream seen, start padding remaining pixels
//   DONE  | all 256 pixels written, oem_finish high

module oem_write_scheduler #(
   parameter logic [7:0] FILL_VALUE = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       so_data,
   input  logic       so_valid,
   input  logic       pi_end,
   output logic [4:0] oem_addr,
   output logic [7:0] oem_dataout,
   output logic       odd1_wr,
   output logic       odd2_wr,
   output logic       odd3_wr,
   output logic       odd4_wr,
   output logic       even1_wr,
   output logic       even2_wr,
   output logic       even3_wr,
   output logic       even4_wr,
   output logic       oem_finish,
   output logic       overflow
);

   localparam int unsigned NPIX     = 256;
   localparam logic [8:0]  LAST_PIX = 9'(NPIX - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_GAP, S_FILL, S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       hold_vld_q, hold_vld_d;
   logic [7:0] hold_q, hold_d;
   logic [8:0] n_q, n_d;
   logic       fill_q, fill_d;
   logic [4:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       ovf_q, ovf_d;

   logic       fill_cond;
   logic       partial_take;
   logic       hold_free;
   logic [7:0] shift_next;
   logic [7:0] partial_byte;
   logic       pulse;
   logic       odd_sel;
   logic [1:0] grp;

   assign shift_next   = {shift_q[6:0], so_data};
   // Low bit_cnt bits hold the partial byte; shift it up so the first bit lands in bit 7.
   assign partial_byte = shift_q << (4'd8 - {1'b0, bit_cnt_q});
   assign fill_cond    = pi_end && !so_valid && !hold_vld_q;

   // Byte assembly runs independently of the write sequence.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      hold_vld_d = hold_vld_q;
      hold_d     = hold_q;
      ovf_d      = ovf_q;
      if (hold_free)    hold_vld_d = 1'b0;
      if (partial_take) bit_cnt_d  = 3'd0;
      if (so_valid) begin
         shift_d   = shift_next;
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            if (state_q == S_DONE) begin
               ovf_d = 1'b1;
            end else begin
               hold_vld_d = 1'b1;
               hold_d     = shift_next;
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      fill_d       = fill_q;
      addr_d       = addr_q;
      data_d       = data_q;
      hold_free    = 1'b0;
      partial_take = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hold_vld_q) begin
               state_d = S_SETUP;
               addr_d  = n_q[5:1];
               data_d  = hold_q;
            end else if (fill_cond) begin
               if (bit_cnt_q != 3'd0) begin
                  // Trailing partial byte goes out as pixel n, then padding follows.
                  state_d      = S_SETUP;
                  addr_d       = n_q[5:1];
                  data_d       = partial_byte;
                  partial_take = 1'b1;
                  fill_d       = 1'b1;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            state_d = S_SETUP;
            fill_d  = 1'b1;
            addr_d  = n_q[5:1];
            data_d  = FILL_VALUE;
         end
         S_SETUP: state_d = S_PULSE;
         S_PULSE: state_d = S_GAP;
         S_GAP: begin
            n_d       = n_q + 9'd1;
            hold_free = 1'b1;
            if (n_q == LAST_PIX) begin
               state_d = S_DONE;
            end else if (fill_q) begin
               state_d = S_SETUP;
               addr_d  = n_d[5:1];
               data_d  = FILL_VALUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         hold_vld_q <= 1'b0;
         hold_q     <= 8'h00;
         n_q        <= 9'd0;
         fill_q     <= 1'b0;
         addr_q     <= 5'd0;
         data_q     <= 8'h00;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         hold_vld_q <= hold_vld_d;
         hold_q     <= hold_d;
         n_q        <= n_d;
         fill_q     <= fill_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         ovf_q      <= ovf_d;
      end
   end

   // Strobes decode straight from registered state so an async reset drops them at once.
   assign pulse   = (state_q == S_PULSE);
   assign odd_sel = ~(n_q[4] ^ n_q[0]);
   assign grp     = n_q[7:6];

   assign odd1_wr  = pulse &  odd_sel & (grp == 2'd0);
   assign odd2_wr  = pulse &  odd_sel & (grp == 2'd1);
   assign odd3_wr  = pulse &  odd_sel & (grp == 2'd2);
   assign odd4_wr  = pulse &  odd_sel & (grp == 2'd3);
   assign even1_wr = pulse & ~odd_sel & (grp == 2'd0);
   assign even2_wr = pulse & ~odd_sel & (grp == 2'd1);
   assign even3_wr = pulse & ~odd_sel & (grp == 2'd2);
   assign even4_wr = pulse & ~odd_sel & (grp == 2'd3);

   assign oem_addr    = addr_q;
   assign oem_dataout = data_q;
   assign oem_finish  = (state_q == S_DONE);
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_oem_write_scheduler.sv
module tb_oem_write_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       so_data = 1'b0;
   logic       so_valid = 1'b0;
   logic       pi_end = 1'b0;
   logic [4:0] oem_addr;
   logic [7:0] oem_dataout;
   logic       odd1_wr, odd2_wr, odd3_wr, odd4_wr;
   logic       even1_wr, even2_wr, even3_wr, even4_wr;
   logic       oem_finish, overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   oem_write_scheduler dut (
      .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid), .pi_end(pi_end),
      .oem_addr(oem_addr), .oem_dataout(oem_dataout),
      .odd1_wr(odd1_wr), .odd2_wr(odd2_wr), .odd3_wr(odd3_wr), .odd4_wr(odd4_wr),
      .even1_wr(even1_wr), .even2_wr(even2_wr), .even3_wr(even3_wr), .even4_wr(even4_wr),
      .oem_finish(oem_finish), .overflow(overflow)
   );

   logic [7:0] wr_vec;
   assign wr_vec = {even4_wr, even3_wr, even2_wr, even1_wr, odd4_wr, odd3_wr, odd2_wr, odd1_wr};

   // Write log captured while strobes are high; bank index 0-3 = ODD1-4, 4-7 = EVEN1-4.
   int         wq_bank[$], wq_addr[$], wq_data[$], wq_paddr[$], wq_pdata[$], wq_fin[$];
   logic       prev_hi = 1'b0;
   logic [4:0] paddr = 5'd0;
   logic [7:0] pdata = 8'h00;
   int         wide_err = 0;
   int         multi_err = 0;
   int         mon_b;
   logic [7:0] mem [8][32];
   logic [7:0] stim [300];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         prev_hi = 1'b0;
      end else begin
         if (wr_vec != 8'h00) begin
            if (prev_hi) wide_err++;
            if (!$onehot(wr_vec)) multi_err++;
            mon_b = 0;
            for (int i = 0; i < 8; i++) if (wr_vec[i]) mon_b = i;
            wq_bank.push_back(mon_b);
            wq_addr.push_back(int'(oem_addr));
            wq_data.push_back(int'(oem_dataout));
            wq_paddr.push_back(int'(paddr));
            wq_pdata.push_back(int'(pdata));
            wq_fin.push_back(int'(oem_finish));
         end
         prev_hi = (wr_vec != 8'h00);
         paddr   = oem_addr;
         pdata   = oem_dataout;
      end
   end

   // Reference: pixel p lives in bank by checkerboard parity and 64-pixel group.
   function automatic int exp_bank(input int p);
      return (((p >> 4) ^ p) & 1) ? 4 + (p >> 6) : (p >> 6);
   endfunction

   function automatic logic [7:0] exp_pix(input int p, input int nb, input int nbits,
                                          input logic [7:0] pb);
      if (p < nb) return stim[p];
      if (p == nb && nbits > 0) return 8'(pb << (8 - nbits));
      return 8'h00;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      int gap;
      gap = $urandom_range(0, 1);
      repeat (gap) begin
         so_valid = 1'b0;
         step();
      end
      so_valid = 1'b1;
      so_data  = b;
      step();
      so_valid = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (3) step();
      chk("reset_outputs", {14'd0, wr_vec, oem_finish, overflow, oem_addr, oem_dataout}, 32'd0);
      reset = 1'b1;
      step();
   endtask

   task automatic run_frame(input int nb, input int nbits, input logic [7:0] pb,
                            input bit do_reset, input string tag);
      int          cyc;
      logic [31:0] got, exp;
      logic [7:0]  px;
      so_valid = 1'b0;
      pi_end   = 1'b0;
      if (do_reset) apply_reset();
      wq_bank.delete(); wq_addr.delete(); wq_data.delete();
      wq_paddr.delete(); wq_pdata.delete(); wq_fin.delete();
      wide_err  = 0;
      multi_err = 0;
      for (int k = 0; k < nb; k++)
         for (int i = 7; i >= 0; i--) send_bit(stim[k][i]);
      for (int i = nbits - 1; i >= 0; i--) send_bit(pb[i]);
      so_valid = 1'b0;
      pi_end   = 1'b1;
      cyc = 0;
      while (!oem_finish && cyc < 2000) begin
         step();
         cyc++;
      end
      chk({tag, "_finish"}, {31'd0, oem_finish}, 32'd1);
      repeat (10) step();
      chk({tag, "_finish_held"}, {31'd0, oem_finish}, 32'd1);
      chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, nb > 256});
      chk({tag, "_write_count"}, wq_bank.size(), 32'd256);
      chk({tag, "_pulse_width"}, wide_err, 32'd0);
      chk({tag, "_onehot"}, multi_err, 32'd0);
      for (int b = 0; b < 8; b++)
         for (int a = 0; a < 32; a++) mem[b][a] = 8'hEE;
      for (int k = 0; k < wq_bank.size() && k < 256; k++) begin
         px  = exp_pix(k, nb, nbits, pb);
         got = {2'b0, 3'(wq_bank[k]), 5'(wq_addr[k]), 8'(wq_data[k]), 5'(wq_paddr[k]),
                8'(wq_pdata[k]), 1'(wq_fin[k])};
         exp = {2'b0, 3'(exp_bank(k)), 5'((k >> 1) & 31), px, 5'((k >> 1) & 31), px, 1'b0};
         chk($sformatf("%s_write%0d", tag, k), got, exp);
         mem[wq_bank[k]][wq_addr[k]] = 8'(wq_data[k]);
      end
      pi_end = 1'b0;
   endtask

   initial begin
      int cyc;
      int nb, nbits;
      logic [7:0] pb;

      stim[0] = 8'hA5;
      run_frame(1, 0, 8'h00, 1'b1, "a5");
      chk("a5_odd1_0", {24'd0, mem[0][0]}, 32'hA5);

      for (int k = 0; k < 256; k++) stim[k] = 8'(k);
      run_frame(256, 0, 8'h00, 1'b1, "ramp");
      chk("ramp_odd1_0",   {24'd0, mem[0][0]},  32'h00);
      chk("ramp_even1_0",  {24'd0, mem[4][0]},  32'h01);
      chk("ramp_even1_8",  {24'd0, mem[4][8]},  32'h10);
      chk("ramp_odd4_31",  {24'd0, mem[3][31]}, 32'hFF);
      chk("ramp_even4_31", {24'd0, mem[7][31]}, 32'hFE);

      for (int k = 0; k < 100; k++) stim[k] = 8'($urandom);
      run_frame(100, 0, 8'h00, 1'b1, "fill100");

      run_frame(0, 3, 8'b0000_0110, 1'b1, "part3");
      chk("part3_odd1_0", {24'd0, mem[0][0]}, 32'hC0);

      run_frame(0, 0, 8'h00, 1'b1, "empty");

      // Async reset in the middle of a write pulse, then a fresh stream.
      so_valid = 1'b0;
      pi_end   = 1'b0;
      apply_reset();
      stim[0] = 8'h3C;
      for (int i = 7; i >= 0; i--) send_bit(stim[0][i]);
      cyc = 0;
      while (wr_vec == 8'h00 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("rst_pulse_seen", {31'd0, wr_vec != 8'h00}, 32'd1);
      #1 reset = 1'b0;
      #1 chk("rst_async", {14'd0, wr_vec, oem_finish, overflow, oem_addr, oem_dataout}, 32'd0);
      repeat (2) step();
      reset = 1'b1;
      step();
      for (int k = 0; k < 5; k++) stim[k] = 8'($urandom);
      run_frame(5, 0, 8'h00, 1'b0, "restart");

      for (int r = 0; r < 3; r++) begin
         nb    = $urandom_range(1, 255);
         nbits = $urandom_range(0, 7);
         pb    = 8'($urandom);
         for (int k = 0; k < nb; k++) stim[k] = 8'($urandom);
         run_frame(nb, nbits, pb, 1'b1, $sformatf("rand%0d", r));
      end

      for (int k = 0; k < 257; k++) stim[k] = 8'($urandom);
      run_frame(257, 0, 8'h00, 1'b1, "ovf");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
